// File: rtl/demux_sipo.sv
// demux_sipo: serial-in, parallel-out demultiplexer.
// Each valid serial bit of a frame is steered to output line sel, so bit i
// of the frame lands on line i. A completed frame is presented on out with a
// one-cycle out_valid pulse.
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - frame start request (IDLE or DONE only)
//   din        - serial data bit
//   din_valid  - din is valid this cycle
//   abort      - discard the frame in progress (SHIFT only)
//   out        - last completed word, registered
//   out_valid  - one-cycle pulse when out is updated
//   sel        - line address of the next bit to be captured
//   busy       - high while shifting a frame
module demux_sipo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SELW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  input  logic             abort,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [SELW-1:0]  sel,
  output logic             busy
);

  localparam logic [SELW-1:0] LAST_SEL = SELW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] staging_q, staging_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             busy_q, busy_d;

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    staging_d   = staging_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sel_d       = sel_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          sel_d     = '0;
          staging_d = '0;
        end
      end
      SHIFT: begin
        // Abort wins over a data bit, including the final one.
        if (abort) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (din_valid) begin
          staging_d[sel_q] = din;
          if (sel_q == LAST_SEL) begin
            // Publish the word including the bit captured on this edge.
            out_d       = staging_d;
            out_valid_d = 1'b1;
            state_d     = DONE;
            sel_d       = '0;
          end else begin
            sel_d = sel_q + SELW'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d   = SHIFT;
          sel_d     = '0;
          staging_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      staging_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      staging_q   <= staging_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign sel       = sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_demux_sipo.sv
// Directed testbench for demux_sipo.
module tb_demux_sipo;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SELW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             din;
  logic             din_valid;
  logic             abort;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [SELW-1:0]  sel;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_sipo #(.WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .abort     (abort),
    .out       (out),
    .out_valid (out_valid),
    .sel       (sel),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Send bits lo..hi of word, one valid bit per cycle.
  task automatic send_bits(input logic [WIDTH-1:0] word, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      din       = word[i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic gap(input int n);
    din_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    abort     = 1'b0;
    tick();
    tick();
    check("rst_out",       32'(out),       32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_sel",       32'(sel),       32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    rst_n = 1'b1;
    tick();

    // Basic frame 16'h016D.
    do_start();
    check("basic_busy_start", 32'(busy), 32'h1);
    check("basic_sel_start",  32'(sel),  32'h0);
    send_bits(16'h016D, 0, 14);
    check("basic_sel_15",     32'(sel),       32'd15);
    check("basic_no_valid",   32'(out_valid), 32'h0);
    check("basic_out_held",   32'(out),       32'h0);
    send_bits(16'h016D, 15, 15);
    check("basic_out",        32'(out),       32'h016D);
    check("basic_valid",      32'(out_valid), 32'h1);
    check("basic_sel_wrap",   32'(sel),       32'h0);
    check("basic_busy_done",  32'(busy),      32'h0);
    tick();
    check("basic_valid_drop", 32'(out_valid), 32'h0);
    check("basic_idle_busy",  32'(busy),      32'h0);
    check("basic_out_keep",   32'(out),       32'h016D);

    // Gapped frame.
    do_start();
    send_bits(16'h016D, 0, 5);
    gap(1);
    check("gap1_sel_a", 32'(sel), 32'd6);
    gap(2);
    check("gap1_sel_b",  32'(sel),  32'd6);
    check("gap1_busy",   32'(busy), 32'h1);
    send_bits(16'h016D, 6, 11);
    gap(1);
    check("gap2_sel",    32'(sel),  32'd12);
    send_bits(16'h016D, 12, 15);
    check("gap_out",     32'(out),       32'h016D);
    check("gap_valid",   32'(out_valid), 32'h1);
    tick();

    // Back-to-back frames: 016D then FFFF with start in the DONE cycle.
    do_start();
    send_bits(16'h016D, 0, 15);
    check("b2b_out1",   32'(out),       32'h016D);
    check("b2b_valid1", 32'(out_valid), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy_restart", 32'(busy),      32'h1);
    check("b2b_sel_restart",  32'(sel),       32'h0);
    check("b2b_valid_drop",   32'(out_valid), 32'h0);
    send_bits(16'hFFFF, 0, 15);
    check("b2b_out2",   32'(out),       32'hFFFF);
    check("b2b_valid2", 32'(out_valid), 32'h1);
    tick();

    // Abort after 9 bits of AAAA.
    do_start();
    send_bits(16'hAAAA, 0, 8);
    check("abort_sel_pre", 32'(sel), 32'd9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",  32'(busy),      32'h0);
    check("abort_sel",   32'(sel),       32'h0);
    check("abort_out",   32'(out),       32'hFFFF);
    check("abort_valid", 32'(out_valid), 32'h0);
    // Abort without start stays idle even with data present.
    send_bits(16'hFFFF, 0, 1);
    check("abort_idle_sel", 32'(sel), 32'h0);
    do_start();
    send_bits(16'h1234, 0, 15);
    check("after_abort_out",   32'(out),       32'h1234);
    check("after_abort_valid", 32'(out_valid), 32'h1);
    tick();

    // Abort beats completion on the final bit.
    do_start();
    send_bits(16'h0F0F, 0, 14);
    din       = 1'b0;
    din_valid = 1'b1;
    abort     = 1'b1;
    tick();
    din_valid = 1'b0;
    abort     = 1'b0;
    check("abort_last_out",   32'(out),       32'h1234);
    check("abort_last_valid", 32'(out_valid), 32'h0);
    check("abort_last_busy",  32'(busy),      32'h0);
    check("abort_last_sel",   32'(sel),       32'h0);

    // Reset mid-frame.
    do_start();
    send_bits(16'hBEEF, 0, 7);
    rst_n = 1'b0;
    din_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    din_valid = 1'b0;
    rst_n = 1'b1;
    check("mrst_out",   32'(out),       32'h0);
    check("mrst_valid", 32'(out_valid), 32'h0);
    check("mrst_sel",   32'(sel),       32'h0);
    check("mrst_busy",  32'(busy),      32'h0);
    send_bits(16'hFFFF, 0, 2);
    check("mrst_nostart_sel",  32'(sel),  32'h0);
    check("mrst_nostart_busy", 32'(busy), 32'h0);

    // start pulses during a frame are ignored.
    do_start();
    for (int i = 0; i < WIDTH; i++) begin
      logic [WIDTH-1:0] w;
      w         = 16'h5A5A;
      din       = w[i];
      din_valid = 1'b1;
      start     = (i == 4 || i == 10);
      tick();
      if (i == 14) begin
        check("ign_sel_14",   32'(sel),       32'd15);
        check("ign_valid_14", 32'(out_valid), 32'h0);
      end
    end
    start     = 1'b0;
    din_valid = 1'b0;
    check("ign_out",   32'(out),       32'h5A5A);
    check("ign_valid", 32'(out_valid), 32'h1);
    tick();
    check("ign_idle_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
